// File: rtl/vga_timing_gen.sv
// VGA raster timing generator and registered output stage.
// Counters feed the colour logic; sync/blank are delayed to match its latency.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 1
) (
  input  logic       clk_25,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       video_active,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pixel_x == H_LAST) begin
      pixel_x <= '0;
      pixel_y <= (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
    end else begin
      pixel_x <= pixel_x + 10'd1;
    end
  end

  // Decoded raster flags, packed as {hs, vs, act, fs}; all-zero means inactive.
  logic       hs, vs, act, fs;
  logic [3:0] dec, dec_d;

  always_comb begin
    hs  = (pixel_x >= HS_START) && (pixel_x <= HS_END);
    vs  = (pixel_y >= VS_START) && (pixel_y <= VS_END);
    act = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    fs  = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    dec = {hs, vs, act, fs};
  end

  if (PIPE_DLY == 0) begin : g_nodly
    assign dec_d = dec;
  end else begin : g_dly
    logic [3:0] stage [PIPE_DLY];
    always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DLY; i++) stage[i] <= '0;
      end else begin
        stage[0] <= dec;
        for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
      end
    end
    assign dec_d = stage[PIPE_DLY-1];
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      vga_hsync    <= ~SYNC_POL;
      vga_vsync    <= ~SYNC_POL;
      video_active <= 1'b0;
      frame_start  <= 1'b0;
      vga_r        <= '0;
      vga_g        <= '0;
      vga_b        <= '0;
    end else begin
      vga_hsync    <= dec_d[3] ? SYNC_POL : ~SYNC_POL;
      vga_vsync    <= dec_d[2] ? SYNC_POL : ~SYNC_POL;
      video_active <= dec_d[1];
      frame_start  <= dec_d[0];
      vga_r        <= dec_d[1] ? in_r : 8'd0;
      vga_g        <= dec_d[1] ? in_g : 8'd0;
      vga_b        <= dec_d[1] ? in_b : 8'd0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a reduced raster on two instances
// (colour latency 1 and 3), reset release, mid-frame async reset, per-frame totals.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 15
  localparam int FRAME = HT * VT;          // 375
  localparam int DLY0 = 1, DLY1 = 3;

  logic clk_25 = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_25 = ~clk_25;

  logic [1:0][23:0] col_in;
  logic [9:0] px0, py0, px1, py1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic hs0, vs0, act0, fs0, hs1, vs1, act1, fs1;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .SYNC_POL(1'b0), .PIPE_DLY(DLY0)) u_dut0 (
    .clk_25(clk_25), .rst(rst), .pixel_x(px0), .pixel_y(py0),
    .in_r(col_in[0][23:16]), .in_g(col_in[0][15:8]), .in_b(col_in[0][7:0]),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hsync(hs0), .vga_vsync(vs0),
    .video_active(act0), .frame_start(fs0));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .SYNC_POL(1'b0), .PIPE_DLY(DLY1)) u_dut1 (
    .clk_25(clk_25), .rst(rst), .pixel_x(px1), .pixel_y(py1),
    .in_r(col_in[1][23:16]), .in_g(col_in[1][15:8]), .in_b(col_in[1][7:0]),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hsync(hs1), .vga_vsync(vs1),
    .video_active(act1), .frame_start(fs1));

  // Observed output vector {hsync, vsync, active, frame_start, r, g, b}
  logic [1:0][27:0] obs;
  logic [1:0][19:0] pos;
  assign obs[0] = {hs0, vs0, act0, fs0, r0, g0, b0};
  assign obs[1] = {hs1, vs1, act1, fs1, r1, g1, b1};
  assign pos[0] = {px0, py0};
  assign pos[1] = {px1, py1};

  localparam logic [27:0] IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mx = 0, my = 0;
  logic rst_next = 1'b1;
  logic [27:0] exp_q [2][$];
  logic [23:0] col_q [2][$];
  int cnt_act = 0, cnt_hs = 0, cnt_vs = 0, cnt_fs = 0;
  localparam int WIN_LO = 400;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int dly_of(input int k);
    return (k == 0) ? DLY0 : DLY1;
  endfunction

  function automatic logic [23:0] colour(input int x, input int y);
    return {8'(x * 5 + 3), 8'(y * 9 + 2) ^ 8'h80, 8'h01};
  endfunction

  // Independent reference: what the outputs must show for counter state (x,y)
  function automatic logic [27:0] model(input int x, input int y);
    logic in_hs, in_vs, vis, first;
    in_hs = (x >= HA + HF) && (x < HA + HF + HS);
    in_vs = (y >= VA + VF) && (y < VA + VF + VS);
    vis   = (x < HA) && (y < VA);
    first = (x == 0) && (y == 0);
    return {~in_hs, ~in_vs, vis, first, vis ? colour(x, y) : 24'h0};
  endfunction

  task automatic refill();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      for (int i = 0; i <= dly_of(k); i++) exp_q[k].push_back(IDLE);
    end
  endtask

  task automatic step();
    logic [27:0] e;
    @(negedge clk_25);
    for (int k = 0; k < 2; k++) begin
      if (exp_q[k].size() == 0) begin
        check(k == 0 ? "scoreboard_empty0" : "scoreboard_empty1", 32'd0, 32'd1);
        e = IDLE;
      end else begin
        e = exp_q[k].pop_front();
      end
      check(k == 0 ? "outputs0" : "outputs1", 32'(obs[k]), 32'(e));
      check(k == 0 ? "pixel_xy0" : "pixel_xy1", 32'(pos[k]), 32'({10'(mx), 10'(my)}));
    end
    if (cyc >= WIN_LO && cyc < WIN_LO + FRAME) begin
      cnt_act += int'(act0);
      cnt_hs  += int'(!hs0);
      cnt_vs  += int'(!vs0);
      cnt_fs  += int'(fs0);
    end
    rst = rst_next;
    for (int k = 0; k < 2; k++) begin
      exp_q[k].push_back(rst ? IDLE : model(mx, my));
      col_q[k].push_back(colour(mx, my));
      if (col_q[k].size() > dly_of(k)) col_in[k] = col_q[k].pop_front();
      else col_in[k] = 24'h0;
    end
    if (!rst) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    cyc++;
  endtask

  initial begin
    col_in = '0;
    refill();
    for (int i = 0; i < 4; i++) step();
    rst_next = 1'b0;
    while (cyc < 1000) step();

    check("active_per_frame", 32'(cnt_act), 32'(HA * VA));
    check("hsync_low_per_frame", 32'(cnt_hs), 32'(HS * VT));
    check("vsync_low_per_frame", 32'(cnt_vs), 32'(VS * HT));
    check("frame_start_per_frame", 32'(cnt_fs), 32'd1);

    // Walk to a mid-line, mid-frame point, then hit reset between edges
    for (int i = 0; i < FRAME && !(mx == 10 && my == 5); i++) step();
    check("reached_reset_point", 32'({10'(mx), 10'(my)}), 32'({10'd10, 10'd5}));
    #2;
    rst = 1'b1;
    rst_next = 1'b1;
    #1;
    check("async_rst_hsync", 32'({hs0, hs1}), 32'b11);
    check("async_rst_vsync", 32'({vs0, vs1}), 32'b11);
    check("async_rst_rgb", 32'({r0, g0, b0} | {r1, g1, b1}), 32'h0);
    check("async_rst_active", 32'({act0, act1, fs0, fs1}), 32'h0);
    check("async_rst_counters", 32'({px0, py0} | {px1, py1}), 32'h0);
    mx = 0;
    my = 0;
    refill();
    for (int i = 0; i < 5; i++) step();
    rst_next = 1'b0;
    for (int i = 0; i < 450; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
